// File: rtl/dp_pkg.sv
// Shared types and constants for the single-bus datapath core.
package dp_pkg;

  typedef enum logic [0:0] {
    MemIdle,
    MemAccess
  } mem_state_e;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefNumGpr = 16;
  localparam int unsigned DefAddrW = 9;

  // Fixed bus sources, indexed after the GPRs (lower index wins the bus).
  localparam int unsigned SrcHi = 0;
  localparam int unsigned SrcLo = 1;
  localparam int unsigned SrcZhi = 2;
  localparam int unsigned SrcZlo = 3;
  localparam int unsigned SrcPc = 4;
  localparam int unsigned SrcMdr = 5;
  localparam int unsigned SrcInport = 6;
  localparam int unsigned SrcC = 7;
  localparam int unsigned NumFixedSrc = 8;

endpackage

// File: rtl/mem_ctrl.sv
// Handshaked memory access sequencer: captures MAR/MDR, holds the request until ack
// or timeout, and keeps a sticky error flag.
module mem_ctrl
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] mar_i,
  input  logic [DATA_W-1:0] mdr_i,
  input  logic              mem_ack_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              mem_err_o,
  output logic              rd_done_o
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] TimeoutLast =
      CntW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    rd_done_o = 1'b0;
    case (state_q)
      MemIdle: begin
        if (read_i ^ write_i) begin
          state_d = MemAccess;
          addr_d  = mar_i;
          wdata_d = mdr_i;
          we_d    = write_i;
          cnt_d   = '0;
        end else if (read_i && write_i) begin
          err_d = 1'b1;
        end
      end
      MemAccess: begin
        // New requests cannot be queued behind an open access.
        if (read_i || write_i) err_d = 1'b1;
        if (mem_ack_i) begin
          state_d   = MemIdle;
          rd_done_o = ~we_q;
        end else if ((MEM_TIMEOUT != 0) && (cnt_q == TimeoutLast)) begin
          state_d = MemIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = MemIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MemIdle;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Decoded from the state register so reset drops the request asynchronously.
  assign mem_req_o   = (state_q == MemAccess);
  assign busy_o      = (state_q == MemAccess);
  assign mem_we_o    = we_q && (state_q == MemAccess);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_err_o   = err_q;

endmodule

// File: rtl/bus_datapath_core.sv
// Single-bus datapath: GPR file, special registers, priority bus mux with conflict
// detection, and a handshaked memory port.
module bus_datapath_core
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned NUM_GPR     = DefNumGpr,
  parameter int unsigned ADDR_W      = DefAddrW,
  parameter int unsigned MEM_TIMEOUT = 0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic [NUM_GPR-1:0]  gpr_in,
  input  logic [NUM_GPR-1:0]  gpr_out,
  input  logic                ba_out,
  input  logic                hi_out,
  input  logic                lo_out,
  input  logic                zhi_out,
  input  logic                zlo_out,
  input  logic                pc_out,
  input  logic                mdr_out,
  input  logic                inport_out,
  input  logic                c_out,
  input  logic                pc_in,
  input  logic                inc_pc,
  input  logic                ir_in,
  input  logic                y_in,
  input  logic                z_in,
  input  logic                hi_in,
  input  logic                lo_in,
  input  logic                mar_in,
  input  logic                mdr_in,
  input  logic                outport_in,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   c_data,
  input  logic [2*DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0]   alu_y,
  output logic [DATA_W-1:0]   bus_out,
  output logic [DATA_W-1:0]   ir_out,
  input  logic [DATA_W-1:0]   inport_data,
  output logic [DATA_W-1:0]   outport_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                bus_conflict,
  output logic                mem_err
);

  localparam int unsigned NumSrc = NUM_GPR + NumFixedSrc;

  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] gpr_val [NUM_GPR];
  logic [DATA_W-1:0] src_val [NumSrc];
  logic [NumSrc-1:0] src_sel;

  logic [DATA_W-1:0] pc_q, ir_q, y_q, zhi_q, zlo_q, hi_q, lo_q, mar_q, mdr_q;
  logic [DATA_W-1:0] inport_q, outport_q;
  logic              rd_done;

  for (genvar g = 0; g < NUM_GPR; g++) begin : g_gpr
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        r_q <= '0;
      end else if (gpr_in[g]) begin
        r_q <= bus;
      end
    end
    assign gpr_val[g] = r_q;
  end

  assign src_sel = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out,
                    gpr_out};

  always_comb begin
    for (int i = 0; i < int'(NUM_GPR); i++) src_val[i] = gpr_val[i];
    // Base-address mode: R0 reads as zero without touching its contents.
    if (ba_out) src_val[0] = '0;
    src_val[NUM_GPR + SrcHi]     = hi_q;
    src_val[NUM_GPR + SrcLo]     = lo_q;
    src_val[NUM_GPR + SrcZhi]    = zhi_q;
    src_val[NUM_GPR + SrcZlo]    = zlo_q;
    src_val[NUM_GPR + SrcPc]     = pc_q;
    src_val[NUM_GPR + SrcMdr]    = mdr_q;
    src_val[NUM_GPR + SrcInport] = inport_q;
    src_val[NUM_GPR + SrcC]      = c_data;
  end

  // Scan from the top down so the lowest asserted index is left on the bus.
  always_comb begin
    bus = '0;
    for (int i = int'(NumSrc) - 1; i >= 0; i--) begin
      if (src_sel[i]) bus = src_val[i];
    end
  end

  assign bus_conflict = ($countones(src_sel) > 1);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pc_q      <= '0;
      ir_q      <= '0;
      y_q       <= '0;
      zhi_q     <= '0;
      zlo_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      mar_q     <= '0;
      mdr_q     <= '0;
      inport_q  <= '0;
      outport_q <= '0;
    end else begin
      inport_q <= inport_data;
      if (pc_in) begin
        pc_q <= bus;
      end else if (inc_pc) begin
        pc_q <= pc_q + DATA_W'(1);
      end
      if (ir_in)      ir_q      <= bus;
      if (y_in)       y_q       <= bus;
      if (hi_in)      hi_q      <= bus;
      if (lo_in)      lo_q      <= bus;
      if (mar_in)     mar_q     <= bus;
      if (outport_in) outport_q <= bus;
      if (z_in) begin
        zhi_q <= alu_result[2*DATA_W-1:DATA_W];
        zlo_q <= alu_result[DATA_W-1:0];
      end
      // Returning read data beats a bus load in the same cycle.
      if (rd_done) begin
        mdr_q <= mem_rdata;
      end else if (mdr_in) begin
        mdr_q <= bus;
      end
    end
  end

  mem_ctrl #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_ctrl (
    .clk_i       (clk),
    .rst_ni      (clr),
    .read_i      (read),
    .write_i     (write),
    .mar_i       (mar_q[ADDR_W-1:0]),
    .mdr_i       (mdr_q),
    .mem_ack_i   (mem_ack),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .busy_o      (busy),
    .mem_err_o   (mem_err),
    .rd_done_o   (rd_done)
  );

  assign bus_out      = bus;
  assign alu_y        = y_q;
  assign ir_out       = ir_q;
  assign outport_data = outport_q;

endmodule

// File: tb/tb_bus_datapath_core.sv
// Directed bench for bus_datapath_core: bus mux, register loads, PC and memory handshake.
module tb_bus_datapath_core;
  localparam int unsigned DW = 32;
  localparam int unsigned NG = 16;
  localparam int unsigned AW = 9;

  logic clk = 1'b0;
  logic clr;
  logic [NG-1:0] gpr_in, gpr_out;
  logic ba_out, hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in;
  logic read, write, mem_ack;
  logic [DW-1:0] c_data, inport_data, mem_rdata;
  logic [2*DW-1:0] alu_result;
  logic [DW-1:0] alu_y, bus_out, ir_out, outport_data, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic mem_req, mem_we, busy, bus_conflict, mem_err;

  int n_total = 0;
  int n_bad = 0;

  bus_datapath_core #(
    .DATA_W      (DW),
    .NUM_GPR     (NG),
    .ADDR_W      (AW),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .gpr_in       (gpr_in),
    .gpr_out      (gpr_out),
    .ba_out       (ba_out),
    .hi_out       (hi_out),
    .lo_out       (lo_out),
    .zhi_out      (zhi_out),
    .zlo_out      (zlo_out),
    .pc_out       (pc_out),
    .mdr_out      (mdr_out),
    .inport_out   (inport_out),
    .c_out        (c_out),
    .pc_in        (pc_in),
    .inc_pc       (inc_pc),
    .ir_in        (ir_in),
    .y_in         (y_in),
    .z_in         (z_in),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .mar_in       (mar_in),
    .mdr_in       (mdr_in),
    .outport_in   (outport_in),
    .read         (read),
    .write        (write),
    .c_data       (c_data),
    .alu_result   (alu_result),
    .alu_y        (alu_y),
    .bus_out      (bus_out),
    .ir_out       (ir_out),
    .inport_data  (inport_data),
    .outport_data (outport_data),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .bus_conflict (bus_conflict),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    gpr_in = '0; gpr_out = '0; ba_out = 0; hi_out = 0; lo_out = 0; zhi_out = 0;
    zlo_out = 0; pc_out = 0; mdr_out = 0; inport_out = 0; c_out = 0;
    pc_in = 0; inc_pc = 0; ir_in = 0; y_in = 0; z_in = 0; hi_in = 0; lo_in = 0;
    mar_in = 0; mdr_in = 0; outport_in = 0; read = 0; write = 0; mem_ack = 0;
  endtask

  // Put a constant on the bus for one edge alongside the given load strobes (already set).
  task automatic load_const(input logic [DW-1:0] v);
    c_data = v; c_out = 1;
    tick();
    idle_inputs();
  endtask

  task automatic peek_gpr(input int idx, input string tag, input logic [DW-1:0] exp);
    idle_inputs();
    gpr_out[idx] = 1'b1;
    #1 check_val(tag, 64'(bus_out), 64'(exp));
    gpr_out = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    clr = 0;
    idle_inputs();
    c_data = '0; alu_result = '0; inport_data = 32'h0000_CAFE; mem_rdata = '0;
    #12;
    check_val("rst_bus", 64'(bus_out), 0);
    check_val("rst_req", 64'(mem_req), 0);
    check_val("rst_busy", 64'(busy), 0);
    check_val("rst_err", 64'(mem_err), 0);
    check_val("rst_we", 64'(mem_we), 0);
    check_val("rst_outport", 64'(outport_data), 0);
    check_val("rst_y", 64'(alu_y), 0);
    check_val("rst_ir", 64'(ir_out), 0);
    tick();
    clr = 1;
    tick();

    // PC <- 0x1234, then R3 <- PC.
    pc_in = 1; load_const(32'h0000_1234);
    pc_out = 1; gpr_in[3] = 1;
    #1 check_val("pc_to_bus", 64'(bus_out), 64'h1234);
    tick(); idle_inputs();
    peek_gpr(3, "r3", 32'h0000_1234);
    for (int i = 0; i < int'(NG); i++) if (i != 3) peek_gpr(i, "gpr_zero", 0);
    hi_out = 1; #1 check_val("hi_zero", 64'(bus_out), 0); hi_out = 0;
    mdr_out = 1; #1 check_val("mdr_zero", 64'(bus_out), 0); mdr_out = 0;
    check_val("no_conflict", 64'(bus_conflict), 0);
    inport_out = 1; #1 check_val("inport", 64'(bus_out), 64'hCAFE); inport_out = 0;

    // Priority and conflict.
    gpr_in[2] = 1; load_const(32'hA);
    hi_in = 1; load_const(32'hB);
    gpr_out[2] = 1; hi_out = 1;
    #1 check_val("prio_bus", 64'(bus_out), 64'hA);
    check_val("prio_conflict", 64'(bus_conflict), 1);
    idle_inputs();
    gpr_in[0] = 1; load_const(32'h55);
    peek_gpr(0, "r0_plain", 32'h55);
    gpr_out[0] = 1; ba_out = 1;
    #1 check_val("ba_zero", 64'(bus_out), 0);
    check_val("ba_conflict", 64'(bus_conflict), 0);
    idle_inputs();
    peek_gpr(0, "r0_kept", 32'h55);

    // Y, IR, outport, LO, Z.
    y_in = 1; ir_in = 1; outport_in = 1; lo_in = 1; load_const(32'h99);
    check_val("alu_y", 64'(alu_y), 64'h99);
    check_val("ir_out", 64'(ir_out), 64'h99);
    check_val("outport", 64'(outport_data), 64'h99);
    lo_out = 1; #1 check_val("lo", 64'(bus_out), 64'h99); lo_out = 0;
    alu_result = 64'h1111_2222_3333_4444; z_in = 1;
    tick(); idle_inputs();
    zhi_out = 1; #1 check_val("zhi", 64'(bus_out), 64'h1111_2222); zhi_out = 0;
    zlo_out = 1; #1 check_val("zlo", 64'(bus_out), 64'h3333_4444); zlo_out = 0;

    // Read: ack in the 4th access cycle; a competing mdr_in on that edge loses.
    mar_in = 1; load_const(32'h10);
    read = 1; tick(); read = 0;
    for (int i = 1; i <= 4; i++) begin
      check_val("rd_busy", 64'(busy), 1);
      check_val("rd_req", 64'(mem_req), 1);
      check_val("rd_addr", 64'(mem_addr), 64'h10);
      check_val("rd_we", 64'(mem_we), 0);
      if (i == 4) begin
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        c_data = 32'h1111; c_out = 1; mdr_in = 1;
      end
      tick();
    end
    idle_inputs();
    check_val("rd_busy_end", 64'(busy), 0);
    check_val("rd_req_end", 64'(mem_req), 0);
    mdr_out = 1; #1 check_val("rd_mdr", 64'(bus_out), 64'hDEAD_BEEF); mdr_out = 0;

    // Write: ack in the 2nd access cycle.
    mdr_in = 1; load_const(32'h77);
    mar_in = 1; load_const(32'h20);
    write = 1; tick(); write = 0;
    for (int i = 1; i <= 2; i++) begin
      check_val("wr_busy", 64'(busy), 1);
      check_val("wr_we", 64'(mem_we), 1);
      check_val("wr_data", 64'(mem_wdata), 64'h77);
      check_val("wr_addr", 64'(mem_addr), 64'h20);
      if (i == 2) begin mem_ack = 1; mem_rdata = 32'h0BAD; end
      tick();
    end
    idle_inputs();
    check_val("wr_busy_end", 64'(busy), 0);
    mdr_out = 1; #1 check_val("wr_mdr", 64'(bus_out), 64'h77); mdr_out = 0;
    check_val("err_clean", 64'(mem_err), 0);

    // Timeout: no ack for 4 access cycles.
    read = 1; tick(); read = 0;
    for (int i = 1; i <= 4; i++) begin
      check_val("to_busy", 64'(busy), 1);
      check_val("to_err_wait", 64'(mem_err), 0);
      tick();
    end
    check_val("to_busy_end", 64'(busy), 0);
    check_val("to_err", 64'(mem_err), 1);
    mdr_out = 1; #1 check_val("to_mdr", 64'(bus_out), 64'h77); mdr_out = 0;

    // PC wrap and pc_in priority.
    pc_in = 1; load_const(32'hFFFF_FFFF);
    inc_pc = 1; tick(); idle_inputs();
    pc_out = 1; #1 check_val("pc_wrap", 64'(bus_out), 0); pc_out = 0;
    pc_in = 1; inc_pc = 1; load_const(32'h40);
    pc_out = 1; #1 check_val("pc_prio", 64'(bus_out), 64'h40); pc_out = 0;

    // Fresh reset, then a read pulse during ACCESS sets the error.
    clr = 0; #1 check_val("err_rst", 64'(mem_err), 0);
    tick(); clr = 1; tick();
    read = 1; tick();
    check_val("dup_busy", 64'(busy), 1);
    check_val("dup_err_before", 64'(mem_err), 0);
    tick(); read = 0;
    check_val("dup_err", 64'(mem_err), 1);
    check_val("dup_busy2", 64'(busy), 1);
    // Reset mid-access drops the request without waiting for a clock edge.
    #2 clr = 0;
    #1 check_val("rst_mid_req", 64'(mem_req), 0);
    check_val("rst_mid_busy", 64'(busy), 0);
    tick(); clr = 1; tick();

    read = 1; write = 1; tick(); idle_inputs();
    check_val("rw_busy", 64'(busy), 0);
    check_val("rw_err", 64'(mem_err), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/bus_datapath_core.md
Name: bus_datapath_core

Overview:
- Parametrised single-bus datapath core for the processor: general-purpose register file, PC, IR, Y, Z (HI/LO halves), HI, LO, MAR, MDR, in/out ports, and the shared bus.
- Successor to the fixed 32-bit/16-register datapath. Adds configurable width and register count, bus-conflict detection, and a handshaked variable-latency memory interface with busy stall and timeout.
- The ALU and the select/encode logic are external. The control unit drives one-hot strobes into this core.

Parameters:
- DATA_W, 32, datapath and bus width.
- NUM_GPR, 16, number of general-purpose registers (2..32).
- ADDR_W, 9, memory address width; taken from MAR[ADDR_W-1:0].
- MEM_TIMEOUT, 0, maximum wait cycles for mem_ack; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- gpr_in  in  NUM_GPR  one-hot GPR load strobes (from bus).
- gpr_out  in  NUM_GPR  GPR bus-drive strobes.
- ba_out  in  1  base-address mode; R0 drives 0.
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out  in  1 each  bus-source strobes.
- pc_in, inc_pc, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in  in  1 each  load strobes.
- read, write  in  1 each  memory request pulses.
- c_data  in  DATA_W  sign-extended constant.
- alu_result  in  2*DATA_W  ALU output.
- alu_y  out  DATA_W  Y register value to ALU.
- bus_out  out  DATA_W  bus value (ALU B operand).
- ir_out  out  DATA_W  IR value.
- inport_data  in  DATA_W  external input.
- outport_data  out  DATA_W  output port register.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write qualifier.
- mem_addr  out  ADDR_W  address.
- mem_wdata  out  DATA_W  write data.
- mem_ack  in  1  memory completion.
- mem_rdata  in  DATA_W  read data.
- busy  out  1  memory access in progress.
- bus_conflict  out  1  more than one bus source asserted (combinational).
- mem_err  out  1  sticky error flag.

Behaviour:
- Reset (clr=0, asynchronous): every register and outport_data = 0; FSM = IDLE; mem_req = mem_we = busy = mem_err = 0.
- Bus source priority, lowest index wins: GPR0..GPR(NUM_GPR-1), HI, LO, ZHI, ZLO, PC, MDR, INPORT, C.
  - No source asserted: bus = 0.
  - bus_conflict = popcount(sources) > 1.
- R0 contributes 0 to the bus when ba_out=1; its stored value is unchanged.
- All loads capture the bus on the rising edge, except:
  - z_in loads ZHI/ZLO from alu_result[2W-1:W] / [W-1:0].
  - The inport register samples inport_data every cycle.
- PC update:
  - pc_in=1: PC <= bus; pc_in has priority over inc_pc.
  - inc_pc=1 alone: PC <= PC+1, wrapping modulo 2^DATA_W.
- Memory FSM states: IDLE, ACCESS.
  - IDLE with read xor write: capture mem_addr <= MAR and mem_wdata <= MDR; mem_we <= write; go to ACCESS. mem_req and busy rise the next cycle.
  - IDLE with read and write both asserted: no access; set mem_err.
  - ACCESS: mem_req held high and address/data stable until mem_ack=1.
  - On ack: if a read, MDR <= mem_rdata; return to IDLE. busy falls and MDR is valid the cycle after ack.
  - Minimum read latency: pulse at cycle n; ack accepted at n+1; MDR valid at n+2.
  - read/write pulses while in ACCESS are dropped and set mem_err.
  - mdr_in in the same cycle as a read ack is ignored; memory data wins. mdr_in in any other cycle loads the bus.
  - MEM_TIMEOUT>0: a counter increments each ACCESS cycle. At MEM_TIMEOUT cycles without ack: return to IDLE, MDR unchanged, set mem_err.
- mem_err clears only on reset.
- Reset mid-access: immediate IDLE; mem_req drops asynchronously.

Decomposition:
- Package dp_pkg:
  - mem state enum.
  - bus source index constants and source count.
  - default width constants.
- Sub-module mem_ctrl: FSM, address/data capture, timeout counter, mem_err.
- Register file and bus mux stay in the core (generate loop).

Test Plan:
- Reset, then drive GPR3 ← bus via pc_out after pc_in loads 0x1234 -> R3=0x00001234; all other registers 0; bus_conflict=0.
- Assert gpr_out[2] and hi_out together with R2=0xA, HI=0xB -> bus=0xA; bus_conflict=1. Then ba_out=1, gpr_out[0] with R0=0x55 -> bus=0.
- MAR=0x10, read pulse; ack 3 cycles after mem_req with rdata=0xDEADBEEF -> mem_addr=0x10 throughout; busy for 4 cycles; MDR=0xDEADBEEF the cycle after ack.
- MDR=0x77, MAR=0x20, write; ack next cycle -> mem_we=1, mem_wdata=0x77, addr=0x20; MDR unchanged; busy for 2 cycles.
- MEM_TIMEOUT=4, read with no ack -> return to IDLE after 4 ACCESS cycles; mem_err=1; MDR unchanged. A second read pulse during ACCESS also sets mem_err.
- PC=0xFFFFFFFF, inc_pc -> PC=0. Then pc_in and inc_pc together with bus=0x40 -> PC=0x40. Reset asserted mid-ACCESS -> mem_req=0 immediately.
